// File: rtl/nor_gate_bist_ctrl.sv
// rtl/nor_gate_bist_ctrl.sv - exhaustive-sweep BIST sequencer for NOR-based universal-gate cells
module nor_gate_bist_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            gate_z,
    output logic [N_IN-1:0] gate_a,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            fail,
    output logic [N_IN-1:0] err_vec
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            exp_z;

    assign exp_z = ~|gate_a;
    assign busy  = (state == S_SETTLE) || (state == S_CHECK);
    assign done  = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            gate_a  <= '0;
            cnt     <= '0;
            pass    <= 1'b0;
            fail    <= 1'b0;
            err_vec <= '0;
        end else if (abort) begin
            state  <= S_IDLE;
            gate_a <= '0;
            cnt    <= '0;
            pass   <= 1'b0;
            fail   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        gate_a  <= '0;
                        cnt     <= CW'(SETTLE - 1);
                        pass    <= 1'b0;
                        fail    <= 1'b0;
                        err_vec <= '0;
                        state   <= S_SETTLE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) state <= S_CHECK;
                    else           cnt   <= cnt - 1'b1;
                end
                S_CHECK: begin
                    // Case-inequality so an X/Z gate output is treated as a mismatch.
                    if (gate_z !== exp_z) begin
                        fail    <= 1'b1;
                        err_vec <= gate_a;
                        state   <= S_DONE;
                    end else if (gate_a == '1) begin
                        pass  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        gate_a <= gate_a + N_IN'(1);
                        cnt    <= CW'(SETTLE - 1);
                        state  <= S_SETTLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nor_gate_bist_ctrl.sv
// tb/tb_nor_gate_bist_ctrl.sv - self-checking bench for nor_gate_bist_ctrl
module tb_nor_gate_bist_ctrl;

    localparam int N = 2;
    localparam int S = 2;
    localparam int P = S + 1;

    logic         clk = 1'b0;
    logic         rst_n, start, abort;
    logic         gate_z = 1'b1;
    logic [N-1:0] gate_a, err_vec;
    logic         busy, done, pass, fail;

    logic         start1;
    logic         gate_z1 = 1'b1;
    logic [0:0]   gate_a1, err_vec1;
    logic         busy1, done1, pass1, fail1;

    int mode, fv;
    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    nor_gate_bist_ctrl #(.N_IN(N), .SETTLE(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_z(gate_z),
        .gate_a(gate_a), .busy(busy), .done(done), .pass(pass), .fail(fail), .err_vec(err_vec)
    );

    nor_gate_bist_ctrl #(.N_IN(1), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .gate_z(gate_z1),
        .gate_a(gate_a1), .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .err_vec(err_vec1)
    );

    // Gate-under-test behaviours: 0 good NOR, 1 stuck-at-1, 2 stuck-at-0, 3 output inverted on vector fv
    function automatic logic gate_fn(int m, int f, int v);
        logic ideal;
        ideal = (v == 0);
        case (m)
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return (v == f) ? ~ideal : ideal;
            default: return ideal;
        endcase
    endfunction

    always @(gate_a, mode, fv) begin
        #1 gate_z = gate_fn(mode, fv, int'(gate_a));
    end

    always @(gate_a1) begin
        #1 gate_z1 = ~gate_a1[0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Reference: first vector whose gate output differs from the ideal NOR ends the sweep.
    task automatic model(input int m, input int f, output logic ep, output logic ef,
                         output int ee, output int lat);
        ep = 1'b1; ef = 1'b0; ee = 0; lat = (1 << N) * P;
        for (int v = 0; v < (1 << N); v++) begin
            if (gate_fn(m, f, v) != (v == 0)) begin
                ep = 1'b0; ef = 1'b1; ee = v; lat = (v + 1) * P;
                break;
            end
        end
    endtask

    task automatic run_sweep(input int m, input int f, input logic ep, input logic ef,
                             input int ee, input int lat);
        int last, ga;
        mode = m; fv = f;
        last = lat / P - 1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int t = 0; t <= lat + 1; t++) begin
            @(negedge clk);
            ga = (t / P < last) ? t / P : last;
            chk("gate_a", 32'(gate_a), 32'(ga));
            chk("busy", 32'(busy), 32'(t < lat));
            chk("done", 32'(done), 32'(t == lat));
            if (t >= lat) begin
                chk("pass", 32'(pass), 32'(ep));
                chk("fail", 32'(fail), 32'(ef));
                if (ef) chk("err_vec", 32'(err_vec), 32'(ee));
            end
        end
    endtask

    typedef struct {
        int   m;
        int   f;
        logic ep;
        logic ef;
        int   ee;
        int   lat;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic ep, ef;
        int   ee, lat;
        bit   seen;

        tbl[0] = '{0, 0, 1'b1, 1'b0, 0, 12};
        tbl[1] = '{1, 0, 1'b0, 1'b1, 1, 6};
        tbl[2] = '{2, 0, 1'b0, 1'b1, 0, 3};
        tbl[3] = '{3, 3, 1'b0, 1'b1, 3, 12};
        tbl[4] = '{3, 2, 1'b0, 1'b1, 2, 9};

        mode = 0; fv = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gate_a", 32'(gate_a), 0);
        chk("rst_done", 32'(done), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run_sweep(tbl[i].m, tbl[i].f, tbl[i].ep, tbl[i].ef, tbl[i].ee, tbl[i].lat);

        // Asynchronous reset during SETTLE of vector 1
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_gate_a", 32'(gate_a), 0);
        chk("arst_pass_fail", 32'({pass, fail}), 0);
        chk("arst_err_vec", 32'(err_vec), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_idle", 32'({busy, done}), 0);

        // Abort mid-sweep: no done pulse, outputs cleared, then a normal sweep
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_gate_a", 32'(gate_a), 0);
        chk("abort_pass_fail", 32'({pass, fail}), 0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 0);
        run_sweep(0, 0, 1'b1, 1'b0, 0, 12);

        // start held high: ignored while busy, restarts directly from DONE
        mode = 0;
        @(negedge clk) start = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("hold_done_seen", 32'(seen), 1);
        chk("hold_pass", 32'(pass), 1);
        @(negedge clk);
        chk("hold_restart_busy", 32'(busy), 1);
        chk("hold_restart_gate_a", 32'(gate_a), 0);
        chk("hold_restart_done", 32'(done), 0);
        start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("hold_second_done", 32'(seen), 1);
        repeat (2) @(negedge clk);
        chk("hold_idle", 32'({busy, done, pass}), 32'b001);

        // Randomized gate faults against the reference model
        for (int i = 0; i < 12; i++) begin
            int m, f;
            m = int'($urandom_range(0, 3));
            f = int'($urandom_range(0, 3));
            model(m, f, ep, ef, ee, lat);
            run_sweep(m, f, ep, ef, ee, lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // NOT-from-NOR cell, N_IN=1, SETTLE=1
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int t = 0; t <= 5; t++) begin
            @(negedge clk);
            chk("not_gate_a", 32'(gate_a1), 32'((t / 2 < 1) ? t / 2 : 1));
            chk("not_busy", 32'(busy1), 32'(t < 4));
            chk("not_done", 32'(done1), 32'(t == 4));
        end
        chk("not_pass_fail", 32'({pass1, fail1}), 32'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
